// File: rtl/fir_pkg.sv
// Shared FIR datapath types and fixed-point format constants.
// Complex fields are packed with I in the MSBs, then Q.
package fir_pkg;

    localparam int unsigned SUM_FRAC  = 23;
    localparam int unsigned COEF_FRAC = 24;
    localparam int unsigned PROD_FRAC = SUM_FRAC + COEF_FRAC;

    typedef struct packed {
        logic signed [23:0] I;
        logic signed [23:0] Q;
    } Samp;

    typedef struct packed {
        logic signed [24:0] I;
        logic signed [24:0] Q;
    } Sum;

    typedef struct packed {
        logic signed [26:0] I;
        logic signed [26:0] Q;
    } Coef;

    typedef struct packed {
        logic signed [51:0] I;
        logic signed [51:0] Q;
    } Partial_product;

    // 9.29 accumulated output format
    typedef struct packed {
        logic signed [37:0] I;
        logic signed [37:0] Q;
    } Full_Product;

endpackage

// File: rtl/signed_mult_25x27.sv
// Combinational exact signed 25x27 -> 52-bit multiply.
module signed_mult_25x27 (
    input  logic signed [24:0] a,
    input  logic signed [26:0] b,
    output logic signed [51:0] p
);

    logic signed [51:0] a_ext;
    logic signed [51:0] b_ext;

    assign a_ext = {{27{a[24]}}, a};
    assign b_ext = {{25{b[26]}}, b};
    assign p     = a_ext * b_ext;

endmodule

// File: rtl/complex_multiplier.sv
// Registered signed complex multiply: 2.23 sum x 3.24 coefficient -> 5.47 product,
// one-cycle latency, wrapping to 52 bits.
module complex_multiplier
    import fir_pkg::*;
(
    input  logic           clk,
    input  Sum             sum,
    input  Coef            coef,
    output Partial_product prod,
    input  logic           reset
);

    logic signed [51:0] p_ii;
    logic signed [51:0] p_qq;
    logic signed [51:0] p_iq;
    logic signed [51:0] p_qi;
    logic signed [52:0] re_wide;
    logic signed [52:0] im_wide;

    signed_mult_25x27 u_mult_ii (.a(sum.I), .b(coef.I), .p(p_ii));
    signed_mult_25x27 u_mult_qq (.a(sum.Q), .b(coef.Q), .p(p_qq));
    signed_mult_25x27 u_mult_iq (.a(sum.I), .b(coef.Q), .p(p_iq));
    signed_mult_25x27 u_mult_qi (.a(sum.Q), .b(coef.I), .p(p_qi));

    // 53-bit add/sub; only the low 52 bits are kept, so the extreme case wraps
    assign re_wide = {p_ii[51], p_ii} - {p_qq[51], p_qq};
    assign im_wide = {p_iq[51], p_iq} + {p_qi[51], p_qi};

    always_ff @(posedge clk) begin
        if (reset) begin
            prod <= '0;
        end else begin
            prod.I <= re_wide[51:0];
            prod.Q <= im_wide[51:0];
        end
    end

endmodule

// File: tb/tb_complex_multiplier.sv
// Bench for complex_multiplier: directed literal cases plus random streaming
// checked every cycle against a plain-arithmetic complex multiply model.
module tb_complex_multiplier;
    import fir_pkg::*;

    logic           clk = 1'b0;
    logic           reset;
    Sum             sum;
    Coef            coef;
    Partial_product prod;

    int n_vec  = 0;
    int n_miss = 0;

    logic [51:0] exp_i;
    logic [51:0] exp_q;
    logic        model_valid = 1'b0;
    logic        done        = 1'b0;

    complex_multiplier dut (
        .clk  (clk),
        .sum  (sum),
        .coef (coef),
        .prod (prod),
        .reset(reset)
    );

    always #5 clk = ~clk;

    // (a+jb)(c+jd) = (ac-bd) + j(ad+bc), computed in 64-bit and wrapped to 52 bits
    function automatic logic [51:0] model_re(Sum s, Coef c);
        longint a, b, cr, d, r;
        a = longint'(s.I); b = longint'(s.Q);
        cr = longint'(c.I); d = longint'(c.Q);
        r = a * cr - b * d;
        return r[51:0];
    endfunction

    function automatic logic [51:0] model_im(Sum s, Coef c);
        longint a, b, cr, d, r;
        a = longint'(s.I); b = longint'(s.Q);
        cr = longint'(c.I); d = longint'(c.Q);
        r = a * d + b * cr;
        return r[51:0];
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            exp_i = '0;
            exp_q = '0;
        end else begin
            exp_i = model_re(sum, coef);
            exp_q = model_im(sum, coef);
        end
        model_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (model_valid && !done) begin
            n_vec++;
            if (prod.I !== exp_i || prod.Q !== exp_q) begin
                n_miss++;
                $display("FAIL model t=%0t prod=(%h,%h) expected=(%h,%h)",
                         $time, prod.I, prod.Q, exp_i, exp_q);
            end
        end
    end

    task automatic drive(input longint si, input longint sq, input longint ci, input longint cq);
        @(posedge clk);
        #1;
        sum.I  = 25'(si);
        sum.Q  = 25'(sq);
        coef.I = 27'(ci);
        coef.Q = 27'(cq);
    endtask

    task automatic check_lit(input string name, input longint ei, input longint eq);
        logic [51:0] wi;
        logic [51:0] wq;
        wi = ei[51:0];
        wq = eq[51:0];
        n_vec++;
        if (prod.I !== wi || prod.Q !== wq) begin
            n_miss++;
            $display("FAIL %s prod=(%h,%h) expected=(%h,%h)", name, prod.I, prod.Q, wi, wq);
        end
    endtask

    // apply one vector, wait for its result edge, check at the following negedge
    task automatic lit_case(input string name, input longint si, input longint sq,
                            input longint ci, input longint cq, input longint ei, input longint eq);
        drive(si, sq, ci, cq);
        @(posedge clk);
        @(negedge clk);
        check_lit(name, ei, eq);
    endtask

    task automatic drive_random(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
            sum.I  = 25'($urandom());
            sum.Q  = 25'($urandom());
            coef.I = 27'($urandom());
            coef.Q = 27'($urandom());
            if ($urandom_range(0, 7) == 0) sum.I  = 25'h1000000;
            if ($urandom_range(0, 7) == 0) coef.Q = 27'h4000000;
        end
    endtask

    initial begin
        reset  = 1'b1;
        sum    = '0;
        coef   = '0;

        // reset dominates data for two edges
        @(posedge clk);
        #1;
        sum.I = 25'h400000; sum.Q = 25'h400000;
        coef.I = 27'h1000000; coef.Q = 27'h1000000;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_lit("reset_hold", 0, 0);
        #1 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_lit("first_after_reset", 0, longint'(1) << 47);

        lit_case("real_x_real", 1 << 22, 0, 1 << 24, 0, longint'(1) << 46, 0);
        lit_case("j_x_j", 0, 1 << 22, 0, 1 << 24, -(longint'(1) << 46), 0);
        lit_case("mixed_signs", 1 << 22, 1 << 22, 1 << 23, -(1 << 23), longint'(1) << 46, 0);
        lit_case("extreme", -(1 << 24), -(1 << 24), -(1 << 26), (1 << 26) - 1,
                 (longint'(1) << 51) - (longint'(1) << 24), longint'(1) << 24);
        lit_case("wrap", -(1 << 24), -(1 << 24), -(1 << 26), -(1 << 26),
                 0, -(longint'(1) << 51));
        lit_case("neg_one_x_small", -(1 << 23), 0, 3, -5, -(3 * (longint'(1) << 23)),
                 5 * (longint'(1) << 23));

        // back-to-back random stream; the model checks every cycle
        drive_random(20);

        // mid-stream reset discards the in-flight product
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_lit("midstream_reset", 0, 0);
        #1 reset = 1'b0;
        drive_random(40);

        @(posedge clk);
        @(negedge clk);
        #1 done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
